// File: rtl/dac_transmitter.sv
// dac_transmitter
//   Buffers 16-bit samples from an AXI-Stream slave into a small synchronous
//   FIFO and plays them out to a DAC at a programmable rate. Playback starts
//   once PREFILL words are buffered, or once the whole packet has arrived if
//   it is shorter than that. In test mode the FIFO is bypassed and a ramp
//   0,1,2,... is played instead.
//
//   Ports
//     ACLK, ARESETN         clock (rising edge), async active-low reset
//     s00_axis_*            sample stream in (tkeep ignored, tlast checked)
//     dac_data, dac_strobe  registered sample and its one-cycle update pulse
//     dsize, rate, test     packet length, cycles per sample, ramp mode;
//                           all captured when a packet is started
//     start                 level request, honoured only while idle
//     sr_pc                 high while idle (previous packet complete)
//     sr_err                sticky underrun / tlast-mismatch flag
module dac_transmitter #(
  parameter int FIFO_DEPTH = 16,
  parameter int PREFILL    = 8
) (
  input  logic        ACLK,
  input  logic        ARESETN,
  input  logic [15:0] s00_axis_tdata,
  input  logic        s00_axis_tvalid,
  output logic        s00_axis_tready,
  input  logic [1:0]  s00_axis_tkeep,
  input  logic        s00_axis_tlast,
  output logic [15:0] dac_data,
  output logic        dac_strobe,
  input  logic [31:0] dsize,
  input  logic [15:0] rate,
  input  logic        test,
  input  logic        start,
  output logic        sr_pc,
  output logic        sr_err
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH_CNT   = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0] PREFILL_CNT = (AW+1)'(PREFILL);

  typedef enum logic [1:0] {S_IDLE, S_FILL, S_RUN, S_DONE} state_t;

  state_t        state_q, state_d;
  logic [31:0]   rem_out_q, rem_out_d;
  logic [31:0]   rem_in_q, rem_in_d;
  logic [15:0]   dsize_lo_q, dsize_lo_d;
  logic [15:0]   rate_q, rate_d;
  logic          test_q, test_d;
  logic [15:0]   rate_cnt_q, rate_cnt_d;
  logic [15:0]   dac_data_q, dac_data_d;
  logic          dac_strobe_q, dac_strobe_d;
  logic          sr_err_q, sr_err_d;
  logic          sr_pc_q, sr_pc_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;

  logic [15:0]   fifo_mem [FIFO_DEPTH];

  logic          fifo_full;
  logic          fifo_empty;
  logic          tready;
  logic          xfer;
  logic          tick;
  logic          pop;
  logic          unused_tkeep;

  assign unused_tkeep = ^s00_axis_tkeep;

  assign fifo_full  = (count_q == DEPTH_CNT);
  assign fifo_empty = (count_q == '0);

  // Only sample-stream mode consumes input, and never beyond the packet
  // length, so stray words after the packet stay upstream.
  assign tready = ((state_q == S_FILL) || (state_q == S_RUN)) && !test_q &&
                  (rem_in_q != 32'd0) && !fifo_full;
  assign xfer   = s00_axis_tvalid && tready;

  // The rate counter is zero on RUN entry, so the first tick lands in the
  // first RUN cycle.
  assign tick = (state_q == S_RUN) && (rate_cnt_q == 16'd0);
  assign pop  = tick && !test_q && !fifo_empty;

  always_comb begin
    state_d      = state_q;
    rem_out_d    = rem_out_q;
    rem_in_d     = rem_in_q;
    dsize_lo_d   = dsize_lo_q;
    rate_d       = rate_q;
    test_d       = test_q;
    rate_cnt_d   = rate_cnt_q;
    dac_data_d   = dac_data_q;
    dac_strobe_d = 1'b0;
    sr_err_d     = sr_err_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;

    case (state_q)
      S_IDLE: begin
        if (start && (dsize != 32'd0)) begin
          state_d    = S_FILL;
          rem_out_d  = dsize;
          rem_in_d   = dsize;
          dsize_lo_d = dsize[15:0];
          rate_d     = (rate == 16'd0) ? 16'd1 : rate;
          test_d     = test;
          rate_cnt_d = 16'd0;
          sr_err_d   = 1'b0;
        end
      end

      S_FILL: begin
        rate_cnt_d = 16'd0;
        if (test_q || (count_q >= PREFILL_CNT) || (rem_in_q == 32'd0)) begin
          state_d = S_RUN;
        end
      end

      S_RUN: begin
        if (tick) begin
          rate_cnt_d   = rate_q - 16'd1;
          dac_strobe_d = 1'b1;
          rem_out_d    = rem_out_q - 32'd1;
          if (test_q) begin
            // Ramp index equals the number of samples already played.
            dac_data_d = dsize_lo_q - rem_out_q[15:0];
          end else if (!fifo_empty) begin
            dac_data_d = fifo_mem[rd_ptr_q];
          end else begin
            // Underrun: keep the old sample but still honour the timing.
            sr_err_d = 1'b1;
          end
          if (rem_out_q == 32'd1) begin
            state_d = S_DONE;
          end
        end else begin
          rate_cnt_d = rate_cnt_q - 16'd1;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (xfer) begin
      rem_in_d = rem_in_q - 32'd1;
      // tlast must mark exactly the final word of the packet.
      if (s00_axis_tlast != (rem_in_q == 32'd1)) begin
        sr_err_d = 1'b1;
      end
      wr_ptr_d = wr_ptr_q + AW'(1);
    end

    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end

    case ({xfer, pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase

    // Anything left over (e.g. words that arrived after an underrun) is
    // discarded when the packet finishes.
    if (state_q == S_DONE) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
  end

  assign sr_pc_d = (state_d == S_IDLE);

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      state_q      <= S_IDLE;
      rem_out_q    <= 32'd0;
      rem_in_q     <= 32'd0;
      dsize_lo_q   <= 16'd0;
      rate_q       <= 16'd0;
      test_q       <= 1'b0;
      rate_cnt_q   <= 16'd0;
      dac_data_q   <= 16'd0;
      dac_strobe_q <= 1'b0;
      sr_err_q     <= 1'b0;
      sr_pc_q      <= 1'b1;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
    end else begin
      state_q      <= state_d;
      rem_out_q    <= rem_out_d;
      rem_in_q     <= rem_in_d;
      dsize_lo_q   <= dsize_lo_d;
      rate_q       <= rate_d;
      test_q       <= test_d;
      rate_cnt_q   <= rate_cnt_d;
      dac_data_q   <= dac_data_d;
      dac_strobe_q <= dac_strobe_d;
      sr_err_q     <= sr_err_d;
      sr_pc_q      <= sr_pc_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
    end
  end

  // Sample storage needs no reset; validity is tracked by count_q.
  always_ff @(posedge ACLK) begin
    if (xfer) begin
      fifo_mem[wr_ptr_q] <= s00_axis_tdata;
    end
  end

  assign s00_axis_tready = tready;
  assign dac_data        = dac_data_q;
  assign dac_strobe      = dac_strobe_q;
  assign sr_pc           = sr_pc_q;
  assign sr_err          = sr_err_q;

endmodule

// File: tb/tb_dac_transmitter.sv
// tb_dac_transmitter
//   Drives packets into dac_transmitter and compares every cycle against a
//   packet-level reference: a queue of accepted words, a prefill rule and a
//   fixed strobe period decide what the DAC should show and when.
module tb_dac_transmitter;

  localparam int DEPTH = 16;
  localparam int PRE   = 8;

  logic        ACLK = 1'b0;
  logic        ARESETN = 1'b1;
  logic [15:0] s00_axis_tdata = 16'd0;
  logic        s00_axis_tvalid = 1'b0;
  logic        s00_axis_tready;
  logic [1:0]  s00_axis_tkeep = 2'b11;
  logic        s00_axis_tlast = 1'b0;
  logic [15:0] dac_data;
  logic        dac_strobe;
  logic [31:0] dsize = 32'd0;
  logic [15:0] rate = 16'd0;
  logic        test = 1'b0;
  logic        start = 1'b0;
  logic        sr_pc;
  logic        sr_err;

  dac_transmitter #(.FIFO_DEPTH(DEPTH), .PREFILL(PRE)) dut (
    .ACLK            (ACLK),
    .ARESETN         (ARESETN),
    .s00_axis_tdata  (s00_axis_tdata),
    .s00_axis_tvalid (s00_axis_tvalid),
    .s00_axis_tready (s00_axis_tready),
    .s00_axis_tkeep  (s00_axis_tkeep),
    .s00_axis_tlast  (s00_axis_tlast),
    .dac_data        (dac_data),
    .dac_strobe      (dac_strobe),
    .dsize           (dsize),
    .rate            (rate),
    .test            (test),
    .start           (start),
    .sr_pc           (sr_pc),
    .sr_err          (sr_err)
  );

  always #5 ACLK = ~ACLK;

  int total = 0;
  int bad   = 0;

  // Every comparison in the bench funnels through here.
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("[TB] FAIL %s: got=%0h want=%0h t=%0t", tag, got, want, $time);
    end
  endtask

  // Reference model state, advanced once per cycle at the falling edge.
  int          cyc = 0;
  bit          mBusy, mRun, mFinish, mStartPend, mTest, mErr, mPend, mPendLast;
  int          mDsz, mRate, mRecv, mStrobes, mNext;
  logic [15:0] mLast, mPendWord;
  logic [15:0] mQ[$];
  int          obsStrobes = 0;

  // Samples are taken mid-cycle; a strobe seen in cycle n belongs to the
  // rising edge just before it, a handshake seen in cycle n completes at the
  // rising edge just after it.
  always @(negedge ACLK) begin
    bit expStrobe;
    bit expReady;
    cyc++;
    if (!ARESETN) begin
      mBusy = 0; mRun = 0; mFinish = 0; mStartPend = 0; mPend = 0;
      mErr = 0; mLast = 16'd0; mQ.delete();
      checkOutput("rstData", 32'(dac_data), 32'd0);
      checkOutput("rstStrobe", 32'(dac_strobe), 32'd0);
      checkOutput("rstReady", 32'(s00_axis_tready), 32'd0);
      checkOutput("rstPc", 32'(sr_pc), 32'd1);
      checkOutput("rstErr", 32'(sr_err), 32'd0);
    end else begin
      expStrobe = 0;
      if (mFinish) begin
        mBusy = 0; mFinish = 0; mQ.delete();
      end
      if (mStartPend) begin
        mBusy = 1; mRun = 0; mErr = 0; mRecv = 0; mStrobes = 0;
        mQ.delete(); mStartPend = 0;
      end
      if (mBusy && mRun && cyc == mNext) begin
        expStrobe = 1;
        if (mTest) mLast = 16'(mStrobes);
        else if (mQ.size() > 0) mLast = mQ.pop_front();
        else mErr = 1;
        mStrobes++;
        mNext = cyc + mRate;
        if (mStrobes == mDsz) mFinish = 1;
      end
      if (mPend) begin
        mQ.push_back(mPendWord);
        mRecv++;
        if (mPendLast != (mRecv == mDsz)) mErr = 1;
        mPend = 0;
      end
      if (mBusy && !mRun && (mTest || mQ.size() >= PRE || mRecv == mDsz)) begin
        mRun = 1;
        mNext = cyc + 2;
      end
      expReady = mBusy && !mFinish && !mTest && (mRecv < mDsz) && (mQ.size() < DEPTH);
      checkOutput("data", 32'(dac_data), 32'(mLast));
      checkOutput("strobe", 32'(dac_strobe), 32'(expStrobe));
      checkOutput("tready", 32'(s00_axis_tready), 32'(expReady));
      checkOutput("srPc", 32'(sr_pc), 32'(!mBusy));
      checkOutput("srErr", 32'(sr_err), 32'(mErr));
      if (dac_strobe) obsStrobes++;
      mPend = s00_axis_tvalid && s00_axis_tready;
      mPendWord = s00_axis_tdata;
      mPendLast = s00_axis_tlast;
      if (!mBusy && start && dsize != 32'd0) begin
        mStartPend = 1;
        mDsz = int'(dsize);
        mRate = (rate == 16'd0) ? 1 : int'(rate);
        mTest = test;
      end
    end
  end

  // Runs one packet: pulses start, feeds words (optionally stalling or with a
  // misplaced tlast) until the DUT is idle again, or resets it mid-packet.
  task automatic applyStimulus(input int dsz, input int rt, input bit tst, input int lastIdx,
                               input int stallAt, input int stallLen, input int validPct,
                               input int resetAt);
    logic [15:0] w;
    int idx = 0;
    int stall = 0;
    int guard = 0;
    int base;
    bit acc;
    bit done = 0;
    bit doRst = 0;
    @(posedge ACLK); #1;
    base = obsStrobes;
    dsize = 32'(dsz); rate = 16'(rt); test = tst; start = 1'b1;
    w = 16'($urandom);
    s00_axis_tvalid = 1'b0;
    @(posedge ACLK); #1;
    start = 1'b0;
    while (!done) begin
      if (idx == stallAt && stall < stallLen) begin
        s00_axis_tvalid = 1'b0;
        stall++;
      end else begin
        s00_axis_tvalid = ($urandom_range(99) < validPct);
      end
      s00_axis_tdata = w;
      s00_axis_tlast = (idx == lastIdx);
      @(negedge ACLK);
      acc = s00_axis_tvalid && s00_axis_tready;
      guard++;
      if (sr_pc) done = 1;
      if (resetAt > 0 && guard == resetAt) begin doRst = 1; done = 1; end
      if (guard > 3000) begin
        checkOutput("timeout", 32'd0, 32'd1);
        done = 1;
      end
      @(posedge ACLK); #1;
      if (acc) begin idx++; w = 16'($urandom); end
    end
    s00_axis_tvalid = 1'b0;
    s00_axis_tlast = 1'b0;
    if (doRst) begin
      #2 ARESETN = 1'b0;
      #1;
      checkOutput("asyncData", 32'(dac_data), 32'd0);
      checkOutput("asyncStrobe", 32'(dac_strobe), 32'd0);
      checkOutput("asyncReady", 32'(s00_axis_tready), 32'd0);
      checkOutput("asyncPc", 32'(sr_pc), 32'd1);
      checkOutput("asyncErr", 32'(sr_err), 32'd0);
      repeat (2) @(posedge ACLK);
      #1 ARESETN = 1'b1;
    end else if (guard <= 3000) begin
      checkOutput("strobeCount", 32'(obsStrobes - base), 32'(dsz));
    end
  endtask

  initial begin
    int d;
    int li;
    #2 ARESETN = 1'b0;
    repeat (3) @(posedge ACLK);
    #1 ARESETN = 1'b1;
    @(negedge ACLK);
    checkOutput("idleAfterReset", 32'(sr_pc), 32'd1);

    applyStimulus(4, 1, 0, 3, -1, 0, 100, 0);
    applyStimulus(20, 3, 0, 19, -1, 0, 100, 0);
    applyStimulus(5, 2, 1, 4, -1, 0, 100, 0);
    checkOutput("rampFinal", 32'(dac_data), 32'd4);

    applyStimulus(10, 1, 0, 9, 8, 30, 100, 0);
    checkOutput("underrunErr", 32'(sr_err), 32'd1);
    applyStimulus(6, 1, 0, 5, -1, 0, 100, 0);
    checkOutput("errCleared", 32'(sr_err), 32'd0);

    applyStimulus(3, 1, 0, 1, -1, 0, 100, 0);
    checkOutput("tlastErr", 32'(sr_err), 32'd1);

    @(posedge ACLK); #1;
    dsize = 32'd0; start = 1'b1;
    repeat (4) @(posedge ACLK);
    #1 start = 1'b0;
    @(negedge ACLK);
    checkOutput("zeroSizeIdle", 32'(sr_pc), 32'd1);

    applyStimulus(16, 2, 0, 15, -1, 0, 100, 20);
    applyStimulus(16, 2, 0, 15, -1, 0, 100, 0);
    applyStimulus(7, 0, 0, 6, -1, 0, 70, 0);

    for (int k = 0; k < 10; k++) begin
      d  = $urandom_range(1, 24);
      li = ($urandom_range(4) == 0) ? $urandom_range(0, d) : d - 1;
      applyStimulus(d, $urandom_range(0, 4), ($urandom_range(4) == 0), li,
                    $urandom_range(0, d), $urandom_range(0, 20),
                    $urandom_range(40, 100), 0);
    end

    repeat (3) @(posedge ACLK);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
